// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths and FSM state encoding for the mem/wb stage
package mem_wb_pkg;

  localparam int IMMEDIATE_WIDTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF        = 64;
  localparam int REG_INDEX_BITS_DEF    = 5;
  localparam int THREAD_INDEX_BITS_DEF = 3;
  localparam int ADDR_WIDTH_DEF        = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - ex2 input, data-memory and writeback signals of the mem/wb stage
interface mem_wb_stage_if
  import mem_wb_pkg::*;
#(
  parameter int IMMEDIATE_WIDTH   = IMMEDIATE_WIDTH_DEF,
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int REG_INDEX_BITS    = REG_INDEX_BITS_DEF,
  parameter int THREAD_INDEX_BITS = THREAD_INDEX_BITS_DEF,
  parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic                         in_increment_flag;
  logic                         in_load_word_flag;
  logic                         in_store_word_flag;
  logic [IMMEDIATE_WIDTH-1:0]   in_immediate;
  logic [THREAD_INDEX_BITS-1:0] in_thread_index;
  logic [REG_INDEX_BITS-1:0]    in_reg_index;
  logic [DATA_WIDTH-1:0]        in_data;

  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic                         mem_req_write;
  logic [ADDR_WIDTH-1:0]        mem_req_addr;
  logic [DATA_WIDTH-1:0]        mem_req_wdata;
  logic                         mem_rsp_valid;
  logic [DATA_WIDTH-1:0]        mem_rsp_rdata;

  logic                         wb_valid;
  logic [THREAD_INDEX_BITS-1:0] wb_thread_index;
  logic [REG_INDEX_BITS-1:0]    wb_reg_index;
  logic [DATA_WIDTH-1:0]        wb_data;
  logic                         err_flags;

  modport slave (
    input  in_valid, in_increment_flag, in_load_word_flag, in_store_word_flag,
    input  in_immediate, in_thread_index, in_reg_index, in_data,
    output in_ready,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output wb_valid, wb_thread_index, wb_reg_index, wb_data, err_flags
  );

  modport master (
    output in_valid, in_increment_flag, in_load_word_flag, in_store_word_flag,
    output in_immediate, in_thread_index, in_reg_index, in_data,
    input  in_ready,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  wb_valid, wb_thread_index, wb_reg_index, wb_data, err_flags
  );

endinterface

// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - replicate the top bit of a narrow field into a wider word
module sign_extender #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 64
) (
  input  logic [IN_WIDTH-1:0]  value,
  output logic [OUT_WIDTH-1:0] extended
);

  assign extended = {{(OUT_WIDTH - IN_WIDTH){value[IN_WIDTH-1]}}, value};

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - load/store execution against data memory and registered register-file writeback
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int IMMEDIATE_WIDTH   = IMMEDIATE_WIDTH_DEF,
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int REG_INDEX_BITS    = REG_INDEX_BITS_DEF,
  parameter int THREAD_INDEX_BITS = THREAD_INDEX_BITS_DEF,
  parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  state_t                       state;
  logic                         accept;
  logic                         is_load;
  logic                         is_mem;
  logic [DATA_WIDTH-1:0]        imm_ext;

  logic                         req_write;
  logic [ADDR_WIDTH-1:0]        req_addr;
  logic [DATA_WIDTH-1:0]        req_wdata;
  logic [THREAD_INDEX_BITS-1:0] pend_thread;
  logic [REG_INDEX_BITS-1:0]    pend_reg;

  logic [THREAD_INDEX_BITS-1:0] wb_thread_q;
  logic [REG_INDEX_BITS-1:0]    wb_reg_q;
  logic [DATA_WIDTH-1:0]        wb_data_q;
  logic                         err_q;
  logic                         unused_ok;

  sign_extender #(
    .IN_WIDTH  (IMMEDIATE_WIDTH),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_sign_extender (
    .value    (bus.in_immediate),
    .extended (imm_ext)
  );

  // A load+store combination resolves as a load; the increment flag needs no distinct path.
  assign is_load   = bus.in_load_word_flag;
  assign is_mem    = bus.in_load_word_flag | bus.in_store_word_flag;
  assign unused_ok = ^{imm_ext[DATA_WIDTH-1:ADDR_WIDTH], bus.in_increment_flag};

  assign bus.in_ready = (state == ST_IDLE) || (state == ST_WB);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.mem_req_valid = (state == ST_REQ);
  assign bus.mem_req_write = bus.mem_req_valid & req_write;
  assign bus.mem_req_addr  = bus.mem_req_valid ? req_addr  : '0;
  assign bus.mem_req_wdata = bus.mem_req_valid ? req_wdata : '0;

  assign bus.wb_valid        = (state == ST_WB);
  assign bus.wb_thread_index = wb_thread_q;
  assign bus.wb_reg_index    = wb_reg_q;
  assign bus.wb_data         = wb_data_q;
  assign bus.err_flags       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      pend_thread <= '0;
      pend_reg    <= '0;
      wb_thread_q <= '0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            state <= req_write ? ST_IDLE : ST_RSP;
          end
        end
        ST_RSP: begin
          if (bus.mem_rsp_valid) begin
            state       <= ST_WB;
            wb_thread_q <= pend_thread;
            wb_reg_q    <= pend_reg;
            wb_data_q   <= bus.mem_rsp_rdata;
          end
        end
        default: begin
          // IDLE and WB both accept; WB falls back to IDLE when nothing arrives.
          if (accept) begin
            if (is_mem) begin
              state       <= ST_REQ;
              req_write   <= ~is_load;
              req_addr    <= is_load ? bus.in_data[ADDR_WIDTH-1:0] : imm_ext[ADDR_WIDTH-1:0];
              req_wdata   <= bus.in_data;
              pend_thread <= bus.in_thread_index;
              pend_reg    <= bus.in_reg_index;
              if (bus.in_load_word_flag && bus.in_store_word_flag) begin
                err_q <= 1'b1;
              end
            end else begin
              state       <= ST_WB;
              wb_thread_q <= bus.in_thread_index;
              wb_reg_q    <= bus.in_reg_index;
              wb_data_q   <= bus.in_data;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized and directed checking of mem_wb_stage against a transaction-level model
module tb_mem_wb_stage;

  logic clk;
  logic reset;

  mem_wb_stage_if ifc ();

  mem_wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: what is outstanding, what the next writeback must be, what the last one was.
  logic        m_busy, m_req_out, m_await_rsp, m_req_write, m_err;
  logic [15:0] m_req_addr;
  logic [63:0] m_req_wdata;
  logic [2:0]  m_lthread;
  logic [4:0]  m_lreg;
  logic        m_wb_due;
  logic [2:0]  m_wb_th, m_last_th;
  logic [4:0]  m_wb_rg, m_last_rg;
  logic [63:0] m_wb_d, m_last_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_req_out = 0; m_await_rsp = 0; m_req_write = 0; m_err = 0;
    m_req_addr = '0; m_req_wdata = '0; m_lthread = '0; m_lreg = '0;
    m_wb_due = 0; m_wb_th = '0; m_wb_rg = '0; m_wb_d = '0;
    m_last_th = '0; m_last_rg = '0; m_last_d = '0;
  endtask

  task automatic compare();
    chk("in_ready", ifc.in_ready, !m_busy);
    chk("mem_req_valid", ifc.mem_req_valid, m_req_out);
    if (m_req_out) begin
      chk("mem_req_write", ifc.mem_req_write, m_req_write);
      chk("mem_req_addr", ifc.mem_req_addr, m_req_addr);
      if (m_req_write) chk("mem_req_wdata", ifc.mem_req_wdata, m_req_wdata);
    end else begin
      chk("mem_req_idle_zero", {ifc.mem_req_write, ifc.mem_req_addr, ifc.mem_req_wdata}, 0);
    end
    chk("wb_valid", ifc.wb_valid, m_wb_due);
    if (m_wb_due) begin
      m_last_th = m_wb_th; m_last_rg = m_wb_rg; m_last_d = m_wb_d;
    end
    chk("wb_thread_index", ifc.wb_thread_index, m_last_th);
    chk("wb_reg_index", ifc.wb_reg_index, m_last_rg);
    chk("wb_data", ifc.wb_data, m_last_d);
    chk("err_flags", ifc.err_flags, m_err);
  endtask

  // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model over the next edge.
  task automatic cycle(input logic iv, input logic ld, input logic st, input logic [15:0] imm,
                       input logic [2:0] th, input logic [4:0] rg, input logic [63:0] d,
                       input logic rdy, input logic rv, input logic [63:0] rd);
    logic        acc;
    logic        due;
    logic [63:0] sx;
    @(negedge clk);
    compare();
    ifc.in_valid = iv; ifc.in_increment_flag = !ld && !st;
    ifc.in_load_word_flag = ld; ifc.in_store_word_flag = st;
    ifc.in_immediate = imm; ifc.in_thread_index = th; ifc.in_reg_index = rg; ifc.in_data = d;
    ifc.mem_req_ready = rdy; ifc.mem_rsp_valid = rv; ifc.mem_rsp_rdata = rd;
    acc = iv && !m_busy;
    due = 0;
    if (m_await_rsp && rv) begin
      due = 1; m_wb_th = m_lthread; m_wb_rg = m_lreg; m_wb_d = rd;
      m_await_rsp = 0; m_busy = 0;
    end
    if (m_req_out && rdy) begin
      m_req_out = 0;
      if (m_req_write) m_busy = 0;
      else m_await_rsp = 1;
    end
    if (acc) begin
      if (ld || st) begin
        sx = {{48{imm[15]}}, imm};
        m_busy = 1; m_req_out = 1;
        m_req_write = st && !ld;
        m_req_addr = ld ? d[15:0] : sx[15:0];
        m_req_wdata = d;
        m_lthread = th; m_lreg = rg;
        if (ld && st) m_err = 1;
      end else begin
        due = 1; m_wb_th = th; m_wb_rg = rg; m_wb_d = d;
      end
    end
    m_wb_due = due;
  endtask

  task automatic idle(input logic rdy, input logic rv, input logic [63:0] rd);
    cycle(0, 0, 0, 16'h0, 3'd0, 5'd0, 64'h0, rdy, rv, rd);
  endtask

  task automatic do_reset(input logic spurious);
    reset = 1;
    ifc.in_valid = 0; ifc.mem_req_ready = 0; ifc.mem_rsp_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    ifc.mem_rsp_valid = spurious;
    ifc.mem_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    model_reset();
  endtask

  initial begin
    logic [2:0] kind;
    reset = 1;
    ifc.in_valid = 0; ifc.in_increment_flag = 0; ifc.in_load_word_flag = 0;
    ifc.in_store_word_flag = 0; ifc.in_immediate = '0; ifc.in_thread_index = '0;
    ifc.in_reg_index = '0; ifc.in_data = '0;
    ifc.mem_req_ready = 0; ifc.mem_rsp_valid = 0; ifc.mem_rsp_rdata = '0;
    do_reset(0);
    chk("reset_in_ready", ifc.in_ready, 1);
    chk("reset_wb_valid", ifc.wb_valid, 0);
    chk("reset_wb_data", ifc.wb_data, 0);
    chk("reset_mem_req_valid", ifc.mem_req_valid, 0);

    // ALU op lands one cycle after accept
    cycle(1, 0, 0, 16'h0, 3'd2, 5'd3, 64'h5, 0, 0, 0);
    idle(0, 0, 0);
    chk("alu_wb_valid", ifc.wb_valid, 1);
    chk("alu_wb_data", ifc.wb_data, 64'h5);
    chk("alu_wb_reg", ifc.wb_reg_index, 3);
    chk("alu_wb_thread", ifc.wb_thread_index, 2);

    // Load: ready after 3 request cycles, response two cycles later
    cycle(1, 1, 0, 16'h0, 3'd1, 5'd7, 64'hFFFF_0000_0000_0040, 0, 0, 0);
    idle(0, 0, 0);
    chk("ld_req_valid", ifc.mem_req_valid, 1);
    chk("ld_req_addr", ifc.mem_req_addr, 16'h0040);
    chk("ld_req_write", ifc.mem_req_write, 0);
    chk("ld_in_ready", ifc.in_ready, 0);
    idle(0, 0, 0);
    idle(1, 0, 0);
    chk("ld_req_addr_held", ifc.mem_req_addr, 16'h0040);
    idle(0, 0, 0);
    idle(0, 1, 64'hDEAD);
    chk("ld_rsp_in_ready", ifc.in_ready, 0);
    idle(0, 0, 0);
    chk("ld_wb_valid", ifc.wb_valid, 1);
    chk("ld_wb_data", ifc.wb_data, 64'hDEAD);

    // Store: no writeback, ready again the cycle after handshake
    cycle(1, 0, 1, 16'hFFFC, 3'd0, 5'd1, 64'h1234, 0, 0, 0);
    idle(1, 0, 0);
    chk("st_req_addr", ifc.mem_req_addr, 16'hFFFC);
    chk("st_req_wdata", ifc.mem_req_wdata, 64'h1234);
    chk("st_req_write", ifc.mem_req_write, 1);
    idle(0, 0, 0);
    chk("st_in_ready", ifc.in_ready, 1);
    chk("st_no_wb", ifc.wb_valid, 0);

    // Four back-to-back ALU ops
    cycle(1, 0, 0, 16'h0, 3'd4, 5'd10, 64'h100, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) cycle(1, 0, 0, 16'h0, 3'd4, 5'(10 + i), 64'h100 + 64'(i), 0, 0, 0);
      else idle(0, 0, 0);
      chk("b2b_wb_valid", ifc.wb_valid, 1);
      chk("b2b_wb_data", ifc.wb_data, 64'h100 + 64'(i - 1));
    end

    // Load and store both set
    cycle(1, 1, 1, 16'h8000, 3'd5, 5'd9, 64'h77, 0, 0, 0);
    idle(1, 0, 0);
    chk("both_req_write", ifc.mem_req_write, 0);
    chk("both_req_addr", ifc.mem_req_addr, 16'h0077);
    chk("both_err", ifc.err_flags, 1);
    idle(0, 1, 64'h55);
    idle(0, 0, 0);
    idle(0, 0, 0);
    chk("both_err_sticky", ifc.err_flags, 1);

    // Reset while waiting for a response, then a stale response
    cycle(1, 1, 0, 16'h0, 3'd3, 5'd4, 64'h20, 0, 0, 0);
    idle(1, 0, 0);
    idle(0, 0, 0);
    do_reset(1);
    idle(0, 0, 0);
    chk("rst_no_wb", ifc.wb_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_err_clear", ifc.err_flags, 0);
    chk("rst_wb_data", ifc.wb_data, 0);
    chk("rst_req_valid", ifc.mem_req_valid, 0);

    // Randomized traffic, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) do_reset(1'($urandom_range(0, 1)));
      kind = 3'($urandom_range(0, 9));
      cycle($urandom_range(0, 3) != 0,
            (kind >= 5 && kind < 7) || kind == 9,
            kind >= 7,
            16'($urandom), 3'($urandom), 5'($urandom), {$urandom, $urandom},
            $urandom_range(0, 2) == 0,
            m_await_rsp ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0),
            {$urandom, $urandom});
    end
    idle(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
